// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter and its future receiver.
// Holds the frame state encoding and the line levels.
package fifo_serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period timer: tick marks the last clk cycle of every CLKS_PER_BIT-cycle bit.
// clear holds the count at zero so the first bit after a clear is full length.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a show-ahead FIFO and shifts each out as start bit, data LSB first,
// stop bit(s); a waiting word is popped on the last stop cycle so frames run gap-free.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_val,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam int SW = 2;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic [BW-1:0]         bit_idx, bit_idx_next;
    logic [SW-1:0]         stop_cnt, stop_cnt_next;
    logic                  tx_next;
    logic                  tick;
    logic                  frame_end;
    logic                  take;
    logic                  baud_clear;

    assign frame_end = (state == STOP) && tick && (stop_cnt == LAST_STOP);
    // Flops are held in reset anyway, so only the outgoing strobe needs the reset gate.
    assign take       = enable && fifo_val && ((state == IDLE) || frame_end);
    assign fifo_read  = take && reset;
    assign busy       = (state != IDLE);
    assign baud_clear = (state == IDLE) || take;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= LINE_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
        end else begin
            state    <= state_next;
            tx       <= tx_next;
            shift    <= shift_next;
            bit_idx  <= bit_idx_next;
            stop_cnt <= stop_cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a hold-value default first so no latch can be inferred.
        state_next    = state;
        tx_next       = tx;
        shift_next    = shift;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;

        case (state)
            IDLE: ;
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    tx_next      = shift[0];
                    shift_next   = shift >> 1;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next    = STOP;
                        tx_next       = LINE_IDLE;
                        stop_cnt_next = '0;
                    end else begin
                        tx_next      = shift[0];
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + BW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next = IDLE;
                    end else begin
                        stop_cnt_next = stop_cnt + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (take) begin
            state_next = START;
            tx_next    = START_BIT;
            shift_next = fifo_data;
        end
    end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Drain-side consumer for the ring FIFO. It pops words through the FIFO's show-ahead read interface (val/dataout/read) and serializes each word onto a single asynchronous line: start bit, data LSB first, stop bit(s). It sits between the FIFO and the chip-level TX pin, and lets producers burst into the FIFO while the line drains at the baud rate.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO's DATA_WIDTH.
CLKS_PER_BIT, 16, clk cycles per line bit; must be >= 2.
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
enable  input  1  permits starting a new frame; does not abort a frame in progress.
fifo_val  input  1  FIFO non-empty; connects to the FIFO val output.
fifo_data  input  DATA_WIDTH  FIFO head word, show-ahead; connects to the FIFO dataout output.
fifo_read  output  1  one-cycle pop strobe; connects to the FIFO read input.
tx  output  1  serial line, idles high.
busy  output  1  high while a frame is on the line.

Behaviour:
- Reset (reset=0): takes effect immediately, without waiting for a clock edge.
  - State goes to IDLE; tx=1; busy=0; fifo_read=0; all counters are cleared.
  - fifo_read is gated by reset, so it stays 0 even if fifo_val=1.
- States: IDLE, START, DATA, STOP. busy=1 exactly when the state is not IDLE.
- Pop condition: take = enable & fifo_val & (state==IDLE | last cycle of STOP).
  - fifo_read = take, combinational, high for one cycle per word.
  - On the same rising edge, the shift register latches fifo_data and the FIFO advances its pointer.
  - Never assert fifo_read when fifo_val=0.
- Timing:
  - tx is registered. If the pop occurs in cycle N, tx=0 (start bit) from the edge ending cycle N.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- Transitions:
  - IDLE -> START on take.
  - START -> DATA after CLKS_PER_BIT cycles; tx = bit 0.
  - DATA shifts right each bit period; DATA -> STOP after DATA_WIDTH bits; tx=1 in STOP.
  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles. On its last cycle: if take, go directly to START (no idle gap); else go to IDLE.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.
  - Bit index is $clog2(DATA_WIDTH)+1 bits.
  - Stop counter counts bit periods up to STOP_BITS.
  - No counter overflows for legal parameters.
- enable deasserted mid-frame: the current frame completes unchanged; no further pop until enable=1.
- fifo_val dropping mid-frame: no effect on the current frame, because the word is already latched.
- Reset mid-frame: tx returns to 1 asynchronously and the partial word is discarded, with no re-pop. After release, the next pop takes the FIFO head.
- fifo_data is sampled only on the take edge; its value at any other time is ignored.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Line level constants: LINE_IDLE=1'b1, START_BIT=1'b0.
- One natural sub-module: baud_tick_gen.
  - Parameter: CLKS_PER_BIT.
  - Inputs: clk, reset, clear.
  - Output: tick, asserted on the last cycle of each bit period.
  - Reused later by the matching receiver.

Test Plan:
1. Reset: hold reset=0 with fifo_val=1, enable=1 -> tx=1, busy=0, fifo_read=0 throughout; release reset -> fifo_read pulses in the first cycle.
2. Single word, CLKS_PER_BIT=4: fifo_data=8'hA5 with one-cycle fifo_val -> one fifo_read pulse. tx is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy is high for 40 cycles, then tx=1 and busy=0.
3. Back-to-back, fifo_val held high with 8'h00 then 8'hFF -> second fifo_read on the 40th cycle of the first frame (last STOP cycle). No idle cycle between frames, exactly 2 pops in 80 cycles, and tx shows 0x00 then 0xFF.
4. Empty FIFO: fifo_val=0, enable=1 for 100 cycles -> fifo_read never asserts, tx=1, busy=0.
5. enable drops at cycle 10 of a frame with fifo_val=1 -> frame completes at cycle 40, no further pop, state IDLE; raising enable pops on the next cycle.
6. Reset pulse at cycle 15 (DATA) -> tx=1 and busy=0 before the next clock edge; after release, the next pop transmits the following FIFO word (8'h3C) in full; total pops = 2.
